// File: rtl/sync_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_pulse_gen                                               |
// | Description : Master-side frame timing source. Emits a periodic synclk     |
// |               pulse at the start of every frame of act_prd bins, each bin  |
// |               DIV clk cycles long. Frame length and pulse width are        |
// |               double-buffered and only switch on frame boundaries.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_pulse_gen #(
   parameter int DIV     = 200,
   parameter int DEF_PRD = 640,
   parameter int DEF_PW  = 20,
   parameter int MIN_PRD = 601
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        cfg_load,
   input  logic [9:0]  cfg_prd,
   input  logic [7:0]  cfg_pw,
   output logic        synclk,
   output logic        frame_start,
   output logic        bin_tick,
   output logic [15:0] frame_cnt,
   output logic        busy,
   output logic        cfg_err
);

   localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
   localparam logic [8:0] PW_MAX    = 9'(DIV - 1);
   localparam logic [9:0] PRD_RST   = 10'(DEF_PRD);
   localparam logic [7:0] PW_RST    = 8'(DEF_PW);
   localparam logic [9:0] PRD_FLOOR = 10'(MIN_PRD);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        load_act;

   logic [7:0]  clk_cnt;
   logic [9:0]  bin_cnt;
   logic [9:0]  act_prd;
   logic [7:0]  act_pw;
   logic [9:0]  pend_prd;
   logic [7:0]  pend_pw;

   logic        running;
   logic        bin_last;
   logic        frame_end;
   logic        frame_head;
   logic        cfg_ok;

   assign running    = (state == RUN);
   assign bin_last   = (clk_cnt == DIV_LAST);
   assign frame_end  = running && bin_last && (bin_cnt == (act_prd - 10'd1));
   assign frame_head = running && (bin_cnt == 10'd0) && (clk_cnt == 8'd0);
   assign cfg_ok     = (cfg_prd >= PRD_FLOOR) && (cfg_pw != 8'd0) &&
                       ({1'b0, cfg_pw} <= PW_MAX);
   assign busy       = running;

   // Next-state logic: leave IDLE on en, leave RUN only at a frame boundary.
   always_comb begin
      state_nxt = state;
      load_act  = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = RUN;
               load_act  = 1'b1;
            end
         end
         RUN: begin
            if (frame_end) begin
               load_act = 1'b1;
               if (!en) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Clock-in-bin and bin-in-frame counters; parked at zero while idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_cnt <= 8'd0;
         bin_cnt <= 10'd0;
      end else if (!running) begin
         clk_cnt <= 8'd0;
         bin_cnt <= 10'd0;
      end else if (bin_last) begin
         clk_cnt <= 8'd0;
         bin_cnt <= frame_end ? 10'd0 : bin_cnt + 10'd1;
      end else begin
         clk_cnt <= clk_cnt + 8'd1;
      end
   end

   // Pending config takes legal loads; active config copies pending at frame start.
   // Active reads the old pending value, so a load on the boundary edge waits a frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_prd <= PRD_RST;
         pend_pw  <= PW_RST;
         act_prd  <= PRD_RST;
         act_pw   <= PW_RST;
      end else begin
         if (cfg_load && cfg_ok) begin
            pend_prd <= cfg_prd;
            pend_pw  <= cfg_pw;
         end
         if (load_act) begin
            act_prd <= pend_prd;
            act_pw  <= pend_pw;
         end
      end
   end

   // Registered outputs, all one cycle behind the counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         synclk      <= 1'b0;
         frame_start <= 1'b0;
         bin_tick    <= 1'b0;
         frame_cnt   <= 16'd0;
         cfg_err     <= 1'b0;
      end else begin
         synclk      <= running && (bin_cnt == 10'd0) && (clk_cnt < act_pw);
         frame_start <= frame_head;
         bin_tick    <= running && bin_last;
         cfg_err     <= cfg_load && !cfg_ok;
         if (frame_head) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sync_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sync_pulse_gen                                            |
// | Description : Self-checking bench for sync_pulse_gen with a short bin      |
// |               (DIV=8) so several full frames fit in a short run.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sync_pulse_gen;

   localparam int DIV   = 8;
   localparam int DPRD  = 640;
   localparam int DPW   = 5;
   localparam int MINP  = 601;
   localparam int LIMIT = 8000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        cfg_load = 1'b0;
   logic [9:0]  cfg_prd = 10'd0;
   logic [7:0]  cfg_pw = 8'd0;
   logic        synclk;
   logic        frame_start;
   logic        bin_tick;
   logic [15:0] frame_cnt;
   logic        busy;
   logic        cfg_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [9:0] prd;
      logic [7:0] pw;
      logic       err;
   } cfg_vec_t;

   cfg_vec_t vecs[6];

   sync_pulse_gen #(
      .DIV     (DIV),
      .DEF_PRD (DPRD),
      .DEF_PW  (DPW),
      .MIN_PRD (MINP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .cfg_load    (cfg_load),
      .cfg_prd     (cfg_prd),
      .cfg_pw      (cfg_pw),
      .synclk      (synclk),
      .frame_start (frame_start),
      .bin_tick    (bin_tick),
      .frame_cnt   (frame_cnt),
      .busy        (busy),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Wait for the next rising edge of synclk, bounded.
   task automatic wait_rise();
      logic prev;
      bit   found;
      prev  = synclk;
      found = 1'b0;
      for (int n = 0; n < LIMIT; n++) begin
         step();
         if (!prev && synclk) begin
            found = 1'b1;
            break;
         end
         prev = synclk;
      end
      chk("wait_rise", 32'(found), 32'd1);
   endtask

   // Called right after a synclk rise; runs to the next rise and measures the frame.
   // Optionally issues one cfg_load and toggles en at given cycle offsets.
   task automatic measure(input int load_at, input logic [9:0] lprd, input logic [7:0] lpw,
                          input int drop_at, input int raise_at,
                          output int period, output int width, output int ticks,
                          output int idle_cyc);
      logic prev;
      period   = 0;
      width    = 0;
      ticks    = 0;
      idle_cyc = 0;
      while (period < LIMIT) begin
         if (synclk)   width++;
         if (bin_tick) ticks++;
         if (!busy)    idle_cyc++;
         if (period == load_at) begin
            cfg_prd  = lprd;
            cfg_pw   = lpw;
            cfg_load = 1'b1;
         end else begin
            cfg_load = 1'b0;
         end
         if (period == drop_at)  en = 1'b0;
         if (period == raise_at) en = 1'b1;
         prev = synclk;
         step();
         period++;
         if (!prev && synclk) break;
      end
      cfg_load = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p, w, t, idl, k, hi, tk;

      vecs[0] = '{prd: 10'd601,  pw: 8'd7, err: 1'b0};
      vecs[1] = '{prd: 10'd640,  pw: 8'd5, err: 1'b0};
      vecs[2] = '{prd: 10'd600,  pw: 8'd1, err: 1'b1};
      vecs[3] = '{prd: 10'd640,  pw: 8'd0, err: 1'b1};
      vecs[4] = '{prd: 10'd640,  pw: 8'd8, err: 1'b1};
      vecs[5] = '{prd: 10'd599,  pw: 8'd3, err: 1'b1};

      // Reset state
      step();
      step();
      chk("rst_synclk", 32'(synclk), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      reset = 1'b1;
      step();
      chk("idle_bin_tick", 32'(bin_tick), 32'd0);
      chk("idle_frame_start", 32'(frame_start), 32'd0);

      // T1: start-up latency and default frames
      en = 1'b1;
      step();
      chk("t1_busy_up", 32'(busy), 32'd1);
      chk("t1_synclk_lat1", 32'(synclk), 32'd0);
      step();
      chk("t1_synclk_rise", 32'(synclk), 32'd1);
      chk("t1_frame_start", 32'(frame_start), 32'd1);
      chk("t1_frame_cnt1", 32'(frame_cnt), 32'd1);
      for (int f = 2; f <= 3; f++) begin
         measure(-1, 10'd0, 8'd0, -1, -1, p, w, t, idl);
         chk("t1_period", 32'(p), 32'(DPRD * DIV));
         chk("t1_width", 32'(w), 32'(DPW));
         chk("t1_bin_ticks", 32'(t), 32'(DPRD));
         chk("t1_frame_cnt", 32'(frame_cnt), 32'(f));
         chk("t1_frame_start", 32'(frame_start), 32'd1);
      end

      // T2: load at bin 100 affects only the next frame
      measure(100 * DIV, 10'd700, 8'd7, -1, -1, p, w, t, idl);
      chk("t2_cur_period", 32'(p), 32'(DPRD * DIV));
      chk("t2_cur_width", 32'(w), 32'(DPW));
      measure(-1, 10'd0, 8'd0, -1, -1, p, w, t, idl);
      chk("t2_new_period", 32'(p), 32'(700 * DIV));
      chk("t2_new_width", 32'(w), 32'd7);
      chk("t2_new_ticks", 32'(t), 32'd700);
      chk("t2_frame_cnt", 32'(frame_cnt), 32'd5);

      // T3: legality table; illegal loads must leave pending untouched
      for (int i = 0; i < 6; i++) begin
         cfg_prd  = vecs[i].prd;
         cfg_pw   = vecs[i].pw;
         cfg_load = 1'b1;
         step();
         cfg_load = 1'b0;
         chk($sformatf("t3_cfg_err_%0d", i), 32'(cfg_err), 32'(vecs[i].err));
         step();
         chk($sformatf("t3_cfg_err_drop_%0d", i), 32'(cfg_err), 32'd0);
      end
      wait_rise();
      measure(-1, 10'd0, 8'd0, -1, -1, p, w, t, idl);
      chk("t3_period", 32'(p), 32'(640 * DIV));
      chk("t3_width", 32'(w), 32'd5);
      chk("t3_frame_cnt", 32'(frame_cnt), 32'd7);

      // T4a: en dropped at bin 300 -> frame completes, then idle
      k = 0;
      while (k < LIMIT) begin
         if (k == 300 * DIV) en = 1'b0;
         step();
         k++;
         if (!busy) break;
      end
      chk("t4_busy_fall_cyc", 32'(k), 32'(DPRD * DIV - 1));
      hi = 0;
      tk = 0;
      for (int n = 0; n < 6000; n++) begin
         step();
         if (synclk)   hi++;
         if (bin_tick) tk++;
      end
      chk("t4_idle_synclk", 32'(hi), 32'd0);
      chk("t4_idle_ticks", 32'(tk), 32'd0);
      chk("t4_idle_frame_cnt", 32'(frame_cnt), 32'd7);

      // T4b: restart, then en low and high again inside a frame -> no gap
      en = 1'b1;
      step();
      chk("t4_restart_busy", 32'(busy), 32'd1);
      chk("t4_restart_lat1", 32'(synclk), 32'd0);
      step();
      chk("t4_restart_rise", 32'(synclk), 32'd1);
      chk("t4_restart_cnt", 32'(frame_cnt), 32'd8);
      measure(-1, 10'd0, 8'd0, 1000, 2000, p, w, t, idl);
      chk("t4_nogap_period", 32'(p), 32'(DPRD * DIV));
      chk("t4_nogap_idle", 32'(idl), 32'd0);
      chk("t4_nogap_cnt", 32'(frame_cnt), 32'd9);

      // T5: async reset during the high phase, restart with defaults
      cfg_prd  = 10'd650;
      cfg_pw   = 8'd6;
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      step();
      chk("t5_pre_synclk", 32'(synclk), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_async_synclk", 32'(synclk), 32'd0);
      chk("t5_async_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      step();
      step();
      reset = 1'b1;
      step();
      chk("t5_restart_busy", 32'(busy), 32'd1);
      chk("t5_restart_lat1", 32'(synclk), 32'd0);
      step();
      chk("t5_restart_rise", 32'(synclk), 32'd1);
      chk("t5_restart_cnt", 32'(frame_cnt), 32'd1);
      measure(-1, 10'd0, 8'd0, -1, -1, p, w, t, idl);
      chk("t5_period", 32'(p), 32'(DPRD * DIV));
      chk("t5_width", 32'(w), 32'(DPW));
      chk("t5_ticks", 32'(t), 32'(DPRD));
      chk("t5_frame_cnt", 32'(frame_cnt), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
